bp_be_issue_pair_arbiter: RTL and testbench

BP_BE_ISSUE_PAIR_ARBITER -- requirements
Module: bp_be_issue_pair_arbiter

---
 rtl/bp_be_issue_pair_arbiter_pkg.sv | 19 +
 rtl/bp_be_issue_pair_arbiter_if.sv | 32 +++
 rtl/bp_be_issue_pair_arbiter_hazard.sv | 45 ++++
 rtl/bp_be_issue_pair_arbiter.sv | 114 +++++++++++
 tb/tb_bp_be_issue_pair_arbiter.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/bp_be_issue_pair_arbiter_pkg.sv
// Shared types and constants for the backend dual-issue pair arbiter.
package bp_be_pkg;

    typedef enum logic [0:0] {
        e_pair  = 1'b0,
        e_split = 1'b1
    } bp_be_pair_state_e;

    // Bit positions inside each slot's 4-bit {fence,csr,long,mem} class field.
    localparam int unsigned cls_mem_lp   = 0;
    localparam int unsigned cls_long_lp  = 1;
    localparam int unsigned cls_csr_lp   = 2;
    localparam int unsigned cls_fence_lp = 3;

    function automatic logic [3:0] slot_class(input logic [7:0] classes, input logic younger);
        slot_class = younger ? classes[7:4] : classes[3:0];
    endfunction

endpackage

// File: rtl/bp_be_issue_pair_arbiter_if.sv
// Pair-issue handshake bundle between the issue queue/hazard detector and the arbiter.
interface bp_be_issue_pair_arbiter_if #(
    parameter int reg_addr_width_p = 5,
    parameter int stat_width_p     = 32
);
    logic [1:0]                    slot_v_i;
    logic [7:0]                    slot_class_i;
    logic [reg_addr_width_p-1:0]   slot1_rd_addr_i;
    logic [1:0]                    slot1_wb_v_i;
    logic [3*reg_addr_width_p-1:0] slot2_rs_addr_i;
    logic [1:0]                    slot2_irs_v_i;
    logic [2:0]                    slot2_frs_v_i;
    logic [1:0]                    dispatch_ready_i;
    logic                          flush_i;
    logic [1:0]                    issue_o;
    logic                          pair_yumi_o;
    logic                          split_o;
    logic [stat_width_p-1:0]       pair_cnt_o;
    logic [stat_width_p-1:0]       single_cnt_o;

    modport master (
        output slot_v_i, slot_class_i, slot1_rd_addr_i, slot1_wb_v_i, slot2_rs_addr_i,
               slot2_irs_v_i, slot2_frs_v_i, dispatch_ready_i, flush_i,
        input  issue_o, pair_yumi_o, split_o, pair_cnt_o, single_cnt_o
    );

    modport slave (
        input  slot_v_i, slot_class_i, slot1_rd_addr_i, slot1_wb_v_i, slot2_rs_addr_i,
               slot2_irs_v_i, slot2_frs_v_i, dispatch_ready_i, flush_i,
        output issue_o, pair_yumi_o, split_o, pair_cnt_o, single_cnt_o
    );
endinterface

// File: rtl/bp_be_issue_pair_arbiter_hazard.sv
// Combinational intra-pair conflict check: structural class clashes plus slot1->slot2 RAW.
module bp_be_pair_hazard
    import bp_be_pkg::*;
#(
    parameter int reg_addr_width_p = 5
) (
    input  logic [7:0]                    slot_class_i,
    input  logic [reg_addr_width_p-1:0]   slot1_rd_addr_i,
    input  logic [1:0]                    slot1_wb_v_i,
    input  logic [3*reg_addr_width_p-1:0] slot2_rs_addr_i,
    input  logic [1:0]                    slot2_irs_v_i,
    input  logic [2:0]                    slot2_frs_v_i,
    output logic                          conflict,
    output logic                          raw
);
    logic [3:0] cls1_s;
    logic [3:0] cls2_s;
    logic [2:0] rs_hit_s;
    logic       iraw_s;
    logic       fraw_s;

    // Address compare of each slot2 source against slot1 destination; x0 is exempt only for integers.
    always_comb begin
        rs_hit_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            rs_hit_s[i] = (slot2_rs_addr_i[i*reg_addr_width_p +: reg_addr_width_p] == slot1_rd_addr_i);
        end
        iraw_s = slot1_wb_v_i[0] & (slot1_rd_addr_i != {reg_addr_width_p{1'b0}})
               & (|(slot2_irs_v_i & rs_hit_s[1:0]));
        fraw_s = slot1_wb_v_i[1] & (|(slot2_frs_v_i & rs_hit_s));
        raw    = iraw_s | fraw_s;
    end

    // Structural class clashes combined with RAW into a single conflict flag.
    always_comb begin
        cls1_s   = slot_class(slot_class_i, 1'b0);
        cls2_s   = slot_class(slot_class_i, 1'b1);
        conflict = (cls1_s[cls_mem_lp] & cls2_s[cls_mem_lp])
                 | (cls1_s[cls_long_lp] & cls2_s[cls_long_lp])
                 | cls1_s[cls_csr_lp] | cls1_s[cls_fence_lp]
                 | cls2_s[cls_csr_lp] | cls2_s[cls_fence_lp]
                 | raw;
    end

endmodule

// File: rtl/bp_be_issue_pair_arbiter.sv
// Dual-issue pair arbiter: issues both slots together or splits them oldest-first.
// Optional statistics counters compiled in with `define BP_BE_ISSUE_PAIR_STATS_EN.
module bp_be_issue_pair_arbiter
    import bp_be_pkg::*;
#(
    parameter int reg_addr_width_p = 5,
    parameter int stat_width_p     = 32
) (
    input logic                         clk_i,
    input logic                         reset_n_i,
    bp_be_issue_pair_arbiter_if.slave   pair_if
);
    bp_be_pair_state_e state_r;
    bp_be_pair_state_e state_n_s;
    logic [1:0]        issue_s;
    logic              yumi_s;
    logic              conflict_s;
    logic              raw_s;

    bp_be_pair_hazard #(.reg_addr_width_p(reg_addr_width_p)) hazard (
        .slot_class_i    (pair_if.slot_class_i),
        .slot1_rd_addr_i (pair_if.slot1_rd_addr_i),
        .slot1_wb_v_i    (pair_if.slot1_wb_v_i),
        .slot2_rs_addr_i (pair_if.slot2_rs_addr_i),
        .slot2_irs_v_i   (pair_if.slot2_irs_v_i),
        .slot2_frs_v_i   (pair_if.slot2_frs_v_i),
        .conflict        (conflict_s),
        .raw             (raw_s)
    );

    // Same-cycle grant decision; reset and flush squash every grant.
    always_comb begin
        issue_s   = 2'b00;
        yumi_s    = 1'b0;
        state_n_s = state_r;
        if (!reset_n_i) begin
            state_n_s = e_pair;
        end else if (pair_if.flush_i) begin
            state_n_s = e_pair;
        end else begin
            case (state_r)
                e_pair: begin
                    if (pair_if.slot_v_i[0] & pair_if.dispatch_ready_i[0]) begin
                        if (!pair_if.slot_v_i[1]) begin
                            issue_s = 2'b01;
                            yumi_s  = 1'b1;
                        end else if (!conflict_s & pair_if.dispatch_ready_i[1]) begin
                            issue_s = 2'b11;
                            yumi_s  = 1'b1;
                        end else begin
                            issue_s   = 2'b01;
                            state_n_s = e_split;
                        end
                    end else begin
                        issue_s = 2'b00;
                    end
                end
                e_split: begin
                    // Pair is held stable upstream, so conflict is not re-evaluated here.
                    if (pair_if.slot_v_i[1] & pair_if.dispatch_ready_i[1]) begin
                        issue_s   = 2'b10;
                        yumi_s    = 1'b1;
                        state_n_s = e_pair;
                    end else begin
                        issue_s = 2'b00;
                    end
                end
                default: begin
                    state_n_s = e_pair;
                end
            endcase
        end
    end

    // Pair/split state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_pair;
        end else begin
            state_r <= state_n_s;
        end
    end

    assign pair_if.issue_o     = issue_s;
    assign pair_if.pair_yumi_o = yumi_s;
    assign pair_if.split_o     = (state_r == e_split);

`ifdef BP_BE_ISSUE_PAIR_STATS_EN
    logic [stat_width_p-1:0] pair_cnt_r;
    logic [stat_width_p-1:0] single_cnt_r;

    // Saturating dual-issue and single-issue cycle counters.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pair_cnt_r   <= {stat_width_p{1'b0}};
            single_cnt_r <= {stat_width_p{1'b0}};
        end else begin
            if ((issue_s == 2'b11) && (pair_cnt_r != {stat_width_p{1'b1}})) begin
                pair_cnt_r <= pair_cnt_r + stat_width_p'(1);
            end
            if ((issue_s == 2'b01 || issue_s == 2'b10) && (single_cnt_r != {stat_width_p{1'b1}})) begin
                single_cnt_r <= single_cnt_r + stat_width_p'(1);
            end
        end
    end

    assign pair_if.pair_cnt_o   = pair_cnt_r;
    assign pair_if.single_cnt_o = single_cnt_r;
`else
    assign pair_if.pair_cnt_o   = {stat_width_p{1'b0}};
    assign pair_if.single_cnt_o = {stat_width_p{1'b0}};
`endif

endmodule

// File: tb/tb_bp_be_issue_pair_arbiter.sv
// Scoreboard bench for bp_be_issue_pair_arbiter: directed scenarios then randomized pairs.
module tb_bp_be_issue_pair_arbiter;
    localparam int W      = 5;
    localparam int STAT_W = 6;
    localparam int CMAX   = (1 << STAT_W) - 1;
`ifdef BP_BE_ISSUE_PAIR_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n_i = 1'b0;
    always #5 clk = ~clk;

    bp_be_issue_pair_arbiter_if #(.reg_addr_width_p(W), .stat_width_p(STAT_W)) bus ();

    bp_be_issue_pair_arbiter #(.reg_addr_width_p(W), .stat_width_p(STAT_W)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n_i),
        .pair_if   (bus)
    );

    typedef struct packed {
        logic [1:0]        issue;
        logic              yumi;
        logic              split;
        logic [STAT_W-1:0] pc;
        logic [STAT_W-1:0] sc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: slot1 of the current pair already went, plus counter totals.
    bit m_older_gone = 1'b0;
    int m_pairs = 0;
    int m_singles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_conflict(input logic [7:0] cls, input logic [W-1:0] rd,
                                        input logic [1:0] wb, input logic [3*W-1:0] rsv,
                                        input logic [1:0] irs, input logic [2:0] frs);
        logic [W-1:0] rs [3];
        bit hit = 1'b0;
        for (int i = 0; i < 3; i++) rs[i] = rsv[i*W +: W];
        if (wb[0] && rd != 0)
            for (int i = 0; i < 2; i++) if (irs[i] && rs[i] == rd) hit = 1'b1;
        if (wb[1])
            for (int i = 0; i < 3; i++) if (frs[i] && rs[i] == rd) hit = 1'b1;
        if (cls[0] && cls[4]) hit = 1'b1;
        if (cls[1] && cls[5]) hit = 1'b1;
        if (cls[2] || cls[3] || cls[6] || cls[7]) hit = 1'b1;
        return hit;
    endfunction

    task automatic step(input logic [1:0] v, input logic [7:0] cls, input logic [W-1:0] rd,
                        input logic [1:0] wb, input logic [3*W-1:0] rs, input logic [1:0] irs,
                        input logic [2:0] frs, input logic [1:0] rdy, input logic fl,
                        input logic rst_drop);
        exp_t       e;
        logic [1:0] grant = 2'b00;
        logic       done_pair = 1'b0;
        @(posedge clk);
        #1;
        bus.slot_v_i = v;         bus.slot_class_i = cls;   bus.slot1_rd_addr_i = rd;
        bus.slot1_wb_v_i = wb;    bus.slot2_rs_addr_i = rs; bus.slot2_irs_v_i = irs;
        bus.slot2_frs_v_i = frs;  bus.dispatch_ready_i = rdy; bus.flush_i = fl;
        reset_n_i = rst_drop ? 1'b0 : 1'b1;
        e.split = rst_drop ? 1'b0 : m_older_gone;
        e.pc    = (STATS_EN && !rst_drop) ? STAT_W'(m_pairs)   : '0;
        e.sc    = (STATS_EN && !rst_drop) ? STAT_W'(m_singles) : '0;
        if (rst_drop || fl) begin
            m_older_gone = 1'b0;
        end else if (!m_older_gone) begin
            if (v[0] && rdy[0]) begin
                if (v[1] && rdy[1] && !ref_conflict(cls, rd, wb, rs, irs, frs)) begin
                    grant = 2'b11; done_pair = 1'b1;
                end else if (v[1]) begin
                    grant = 2'b01; m_older_gone = 1'b1;
                end else begin
                    grant = 2'b01; done_pair = 1'b1;
                end
            end
        end else if (v[1] && rdy[1]) begin
            grant = 2'b10; done_pair = 1'b1; m_older_gone = 1'b0;
        end
        if (rst_drop) begin
            m_pairs = 0; m_singles = 0;
        end else if (grant == 2'b11) begin
            if (m_pairs < CMAX) m_pairs++;
        end else if (grant != 2'b00) begin
            if (m_singles < CMAX) m_singles++;
        end
        e.issue = grant;
        e.yumi  = done_pair;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every presented output cycle against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("issue_o", 32'(bus.issue_o), 32'(mon_e.issue));
            chk("pair_yumi_o", 32'(bus.pair_yumi_o), 32'(mon_e.yumi));
            chk("split_o", 32'(bus.split_o), 32'(mon_e.split));
            chk("pair_cnt_o", 32'(bus.pair_cnt_o), 32'(mon_e.pc));
            chk("single_cnt_o", 32'(bus.single_cnt_o), 32'(mon_e.sc));
        end
    end

    logic [1:0]     cv, cwb, cirs, crdy;
    logic [7:0]     ccls;
    logic [W-1:0]   crd;
    logic [3*W-1:0] crs;
    logic [2:0]     cfrs;

    initial begin
        // Reset held with an otherwise issuable pair on the inputs.
        step(2'b11, 8'h00, W'(5), 2'b01, {W'(0), W'(0), W'(6)}, 2'b01, 3'b000, 2'b11, 1'b0, 1'b1);
        // Independent ALU pair issues together.
        step(2'b11, 8'h00, W'(5), 2'b01, {W'(0), W'(0), W'(6)}, 2'b01, 3'b000, 2'b11, 1'b0, 1'b0);
        // Integer RAW x5 splits the pair.
        repeat (2) step(2'b11, 8'h00, W'(5), 2'b01, {W'(0), W'(0), W'(5)}, 2'b01, 3'b000, 2'b11, 1'b0, 1'b0);
        // x0 integer dependency is not a hazard.
        step(2'b11, 8'h00, W'(0), 2'b01, {W'(0), W'(0), W'(0)}, 2'b01, 3'b000, 2'b11, 1'b0, 1'b0);
        // f0 float dependency is a hazard.
        repeat (2) step(2'b11, 8'h00, W'(0), 2'b10, {W'(0), W'(0), W'(0)}, 2'b00, 3'b001, 2'b11, 1'b0, 1'b0);
        // Both mem: slot2 stalls three cycles on ready then issues.
        step(2'b11, 8'h11, W'(1), 2'b00, {W'(2), W'(3), W'(4)}, 2'b00, 3'b000, 2'b11, 1'b0, 1'b0);
        repeat (3) step(2'b11, 8'h11, W'(1), 2'b00, {W'(2), W'(3), W'(4)}, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0);
        step(2'b11, 8'h11, W'(1), 2'b00, {W'(2), W'(3), W'(4)}, 2'b00, 3'b000, 2'b11, 1'b0, 1'b0);
        // Flush in split with ready=11 squashes slot2.
        step(2'b11, 8'h04, W'(1), 2'b00, {W'(2), W'(3), W'(4)}, 2'b00, 3'b000, 2'b11, 1'b0, 1'b0);
        step(2'b11, 8'h04, W'(1), 2'b00, {W'(2), W'(3), W'(4)}, 2'b00, 3'b000, 2'b11, 1'b1, 1'b0);
        step(2'b00, 8'h00, W'(1), 2'b00, {W'(2), W'(3), W'(4)}, 2'b00, 3'b000, 2'b11, 1'b0, 1'b0);
        // Lone older slot, lone younger slot, and older slot not ready.
        step(2'b01, 8'h08, W'(1), 2'b00, {W'(2), W'(3), W'(4)}, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0);
        step(2'b10, 8'h00, W'(1), 2'b00, {W'(2), W'(3), W'(4)}, 2'b00, 3'b000, 2'b11, 1'b0, 1'b0);
        step(2'b11, 8'h00, W'(1), 2'b00, {W'(2), W'(3), W'(4)}, 2'b00, 3'b000, 2'b10, 1'b0, 1'b0);
        // Async reset mid-split abandons slot2.
        step(2'b11, 8'h22, W'(1), 2'b00, {W'(2), W'(3), W'(4)}, 2'b00, 3'b000, 2'b11, 1'b0, 1'b0);
        step(2'b11, 8'h22, W'(1), 2'b00, {W'(2), W'(3), W'(4)}, 2'b00, 3'b000, 2'b11, 1'b0, 1'b1);

        for (int n = 0; n < 2000; n++) begin
            if (!m_older_gone) begin
                cv   = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom);
                ccls = 8'h00;
                for (int b = 0; b < 8; b++) if ($urandom_range(0, 5) == 0) ccls[b] = 1'b1;
                crd  = W'($urandom_range(0, 3));
                cwb  = 2'($urandom);
                crs  = {W'($urandom_range(0, 3)), W'($urandom_range(0, 3)), W'($urandom_range(0, 3))};
                cirs = 2'($urandom);
                cfrs = 3'($urandom);
            end
            crdy = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'($urandom);
            step(cv, ccls, crd, cwb, crs, cirs, cfrs, crdy,
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
